// File: rtl/traffic_phase_sequencer.sv
// Six-phase, four-approach traffic light sequencer with side-road demand skipping
// and a flashing-amber maintenance mode. Phase durations are counted in prescaled ticks.
module traffic_phase_sequencer #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned T_S1     = 7,
    parameter int unsigned T_S2     = 2,
    parameter int unsigned T_S3     = 5,
    parameter int unsigned T_S4     = 2,
    parameter int unsigned T_S5     = 3,
    parameter int unsigned T_S6     = 2,
    parameter int unsigned FLASH_T  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             side_req,
    input  logic             flash,
    output logic [2:0]       light_M1,
    output logic [2:0]       light_MT,
    output logic [2:0]       light_M2,
    output logic [2:0]       light_S,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] count,
    output logic             tick
);

    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    localparam logic [2:0] PH_S1    = 3'd0;
    localparam logic [2:0] PH_S2    = 3'd1;
    localparam logic [2:0] PH_S3    = 3'd2;
    localparam logic [2:0] PH_S4    = 3'd3;
    localparam logic [2:0] PH_S5    = 3'd4;
    localparam logic [2:0] PH_S6    = 3'd5;
    localparam logic [2:0] PH_FLASH = 3'd6;

    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_A   = 3'b010;
    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    localparam logic [11:0] LAMPS_S1 = {LAMP_G, LAMP_R, LAMP_G, LAMP_R};

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [2:0]       phase_q, phase_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             side_pend_q, side_pend_d;
    logic             lamp_on_q, lamp_on_d;
    logic [11:0]      lamps_q, lamps_d;
    logic             phase_end;

    function automatic logic [CNT_W-1:0] term_of(input logic [2:0] ph);
        case (ph)
            PH_S1:   term_of = CNT_W'(T_S1);
            PH_S2:   term_of = CNT_W'(T_S2);
            PH_S3:   term_of = CNT_W'(T_S3);
            PH_S4:   term_of = CNT_W'(T_S4);
            PH_S5:   term_of = CNT_W'(T_S5);
            PH_S6:   term_of = CNT_W'(T_S6);
            default: term_of = CNT_W'(FLASH_T);
        endcase
    endfunction

    // Lamp word is {M1, MT, M2, S}.
    function automatic logic [11:0] lamps_of(input logic [2:0] ph, input logic on);
        case (ph)
            PH_S2:    lamps_of = {LAMP_G, LAMP_R, LAMP_A, LAMP_R};
            PH_S3:    lamps_of = {LAMP_G, LAMP_G, LAMP_R, LAMP_R};
            PH_S4:    lamps_of = {LAMP_A, LAMP_A, LAMP_R, LAMP_R};
            PH_S5:    lamps_of = {LAMP_R, LAMP_R, LAMP_R, LAMP_G};
            PH_S6:    lamps_of = {LAMP_R, LAMP_R, LAMP_R, LAMP_A};
            PH_FLASH: lamps_of = on ? {4{LAMP_A}} : {4{LAMP_OFF}};
            default:  lamps_of = LAMPS_S1;
        endcase
    endfunction

    assign tick      = (pre_q == PRE_LAST);
    assign pre_d     = tick ? '0 : pre_q + 1'b1;
    assign phase_end = (count_q == term_of(phase_q));

    always_comb begin
        phase_d   = phase_q;
        count_d   = count_q;
        lamp_on_d = lamp_on_q;
        if (tick) begin
            case (phase_q)
                PH_FLASH: begin
                    if (!flash) begin
                        phase_d = PH_S1;
                        count_d = '0;
                    end else if (phase_end) begin
                        lamp_on_d = ~lamp_on_q;
                        count_d   = '0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                PH_S1, PH_S2, PH_S3, PH_S4, PH_S5, PH_S6: begin
                    if (!phase_end) begin
                        count_d = count_q + 1'b1;
                    end else begin
                        count_d = '0;
                        if (flash) begin
                            phase_d   = PH_FLASH;
                            lamp_on_d = 1'b1;
                        end else begin
                            case (phase_q)
                                PH_S1:   phase_d = PH_S2;
                                PH_S2:   phase_d = PH_S3;
                                PH_S3:   phase_d = PH_S4;
                                PH_S4:   phase_d = (side_pend_q | side_req) ? PH_S5 : PH_S1;
                                PH_S5:   phase_d = PH_S6;
                                default: phase_d = PH_S1;
                            endcase
                        end
                    end
                end
                default: begin
                    phase_d = PH_S1;
                    count_d = '0;
                end
            endcase
        end
    end

    // Entering S5 consumes the demand, even if side_req is still high on that edge.
    always_comb begin
        side_pend_d = side_pend_q | side_req;
        if (phase_d == PH_S5 && phase_q != PH_S5) begin
            side_pend_d = 1'b0;
        end
    end

    assign lamps_d = lamps_of(phase_d, lamp_on_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q       <= '0;
            phase_q     <= PH_S1;
            count_q     <= '0;
            side_pend_q <= 1'b0;
            lamp_on_q   <= 1'b0;
            lamps_q     <= LAMPS_S1;
        end else begin
            pre_q       <= pre_d;
            phase_q     <= phase_d;
            count_q     <= count_d;
            side_pend_q <= side_pend_d;
            lamp_on_q   <= lamp_on_d;
            lamps_q     <= lamps_d;
        end
    end

    assign light_M1 = lamps_q[11:9];
    assign light_MT = lamps_q[8:6];
    assign light_M2 = lamps_q[5:3];
    assign light_S  = lamps_q[2:0];
    assign phase    = phase_q;
    assign count    = count_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Randomized bench: two sequencers (PRESCALE 1 and 4) share stimulus and are compared every
// clock against a phase-table reference model.
module tb_traffic_phase_sequencer;

    localparam int FLASH_T = 1;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] A = 3'b010;
    localparam logic [2:0] R = 3'b100;

    logic       clk = 1'b0;
    logic       rst;
    logic       side_req;
    logic       flash;
    logic [2:0] m1 [2];
    logic [2:0] mt [2];
    logic [2:0] m2 [2];
    logic [2:0] ls [2];
    logic [2:0] ph [2];
    logic [7:0] cnt [2];
    logic       tk [2];

    int total = 0;
    int bad   = 0;

    int          pres [2] = '{1, 4};
    string       name [2] = '{"p1", "p4"};
    int          dur  [6] = '{7, 2, 5, 2, 3, 2};
    logic [11:0] pat  [6] = '{{G, R, G, R}, {G, R, A, R}, {G, G, R, R},
                              {A, A, R, R}, {R, R, R, G}, {R, R, R, A}};

    int m_pre [2];
    int m_ph  [2];
    int m_cnt [2];
    bit m_pend[2];
    bit m_on  [2];

    traffic_phase_sequencer #(.PRESCALE(1)) u_p1 (
        .clk(clk), .rst(rst), .side_req(side_req), .flash(flash),
        .light_M1(m1[0]), .light_MT(mt[0]), .light_M2(m2[0]), .light_S(ls[0]),
        .phase(ph[0]), .count(cnt[0]), .tick(tk[0])
    );

    traffic_phase_sequencer #(.PRESCALE(4)) u_p4 (
        .clk(clk), .rst(rst), .side_req(side_req), .flash(flash),
        .light_M1(m1[1]), .light_MT(mt[1]), .light_M2(m2[1]), .light_S(ls[1]),
        .phase(ph[1]), .count(cnt[1]), .tick(tk[1])
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pre[i]  = 0;
            m_ph[i]   = 0;
            m_cnt[i]  = 0;
            m_pend[i] = 1'b0;
            m_on[i]   = 1'b0;
        end
    endtask

    // One clock of the sequencer rules, using the inputs present before the edge.
    task automatic model_step(input int i);
        int  old_ph;
        bit  demand;
        old_ph = m_ph[i];
        demand = m_pend[i] || side_req;
        if (m_pre[i] == pres[i] - 1) begin
            if (m_ph[i] == 6) begin
                if (!flash) begin
                    m_ph[i]  = 0;
                    m_cnt[i] = 0;
                end else if (m_cnt[i] == FLASH_T) begin
                    m_on[i]  = !m_on[i];
                    m_cnt[i] = 0;
                end else begin
                    m_cnt[i]++;
                end
            end else if (m_cnt[i] < dur[m_ph[i]]) begin
                m_cnt[i]++;
            end else begin
                m_cnt[i] = 0;
                if (flash) begin
                    m_ph[i] = 6;
                    m_on[i] = 1'b1;
                end else if (m_ph[i] == 3) begin
                    m_ph[i] = demand ? 4 : 0;
                end else begin
                    m_ph[i] = (m_ph[i] + 1) % 6;
                end
            end
        end
        m_pre[i] = (m_pre[i] + 1) % pres[i];
        if (m_ph[i] == 4 && old_ph != 4) m_pend[i] = 1'b0;
        else if (side_req) m_pend[i] = 1'b1;
    endtask

    task automatic check_all(input string when);
        logic [11:0] exp_l;
        for (int i = 0; i < 2; i++) begin
            if (m_ph[i] == 6) exp_l = m_on[i] ? {4{A}} : 12'h000;
            else exp_l = pat[m_ph[i]];
            check_val({when, ".", name[i], ".phase"}, 32'(ph[i]), 32'(m_ph[i]));
            check_val({when, ".", name[i], ".count"}, 32'(cnt[i]), 32'(m_cnt[i]));
            check_val({when, ".", name[i], ".tick"}, 32'(tk[i]), 32'(m_pre[i] == pres[i] - 1));
            check_val({when, ".", name[i], ".lamps"}, 32'({m1[i], mt[i], m2[i], ls[i]}),
                      32'(exp_l));
        end
    endtask

    initial begin
        bit did_s5_reset;
        bit do_reset;
        did_s5_reset = 1'b0;
        rst      = 1'b1;
        side_req = 1'b0;
        flash    = 1'b0;
        model_reset();
        #3;
        check_all("rst");
        #9 rst = 1'b0;

        for (int cyc = 0; cyc < 3800; cyc++) begin
            if (cyc < 300) begin
                side_req = 1'b0;
                flash    = 1'b0;
            end else if (cyc < 1200) begin
                side_req = ($urandom_range(0, 39) == 0);
            end else if (cyc < 1600) begin
                side_req = 1'b1;
            end else if (cyc < 3600) begin
                side_req = ($urandom_range(0, 29) == 0);
                if ($urandom_range(0, 149) == 0) flash = ~flash;
            end else begin
                side_req = 1'b0;
                flash    = 1'b0;
            end

            @(posedge clk);
            model_step(0);
            model_step(1);
            @(negedge clk);
            check_all("run");

            do_reset = 1'b0;
            if (!did_s5_reset && cyc > 400 && m_ph[0] == 4) begin
                did_s5_reset = 1'b1;
                do_reset     = 1'b1;
            end else if (cyc >= 1600 && $urandom_range(0, 799) == 0) begin
                do_reset = 1'b1;
            end
            if (do_reset) begin
                #2 rst = 1'b1;
                #1;
                model_reset();
                check_all("arst");
                @(posedge clk);
                #2 rst = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traffic_phase_sequencer.md
# traffic_phase_sequencer

Parametrised four-approach traffic light sequencer for the intersection controller. It drives main-road (M1, MT turn, M2) and side-road (S) lamp groups through a six-phase cycle. Each phase duration is set by a parameter and counted in prescaled ticks. Side-road phases are skipped unless demand is registered, and a flashing-amber maintenance mode is available.

## Interface
Parameters:
- CNT_W, 8: width of the phase tick counter; every T_* and FLASH_T must be ≤ 2^CNT_W−1.
- PRESCALE, 1: clk cycles per tick; must be ≥1 (1 = tick every clock).
- T_S1, 7 / T_S2, 2 / T_S3, 5 / T_S4, 2 / T_S5, 3 / T_S6, 2: terminal count per phase; phase Sn lasts T_Sn+1 ticks.
- FLASH_T, 1: terminal count per flash half-period (lamp on/off each lasts FLASH_T+1 ticks).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- side_req  in  1  side-road demand, level, sampled every clk.
- flash  in  1  flashing-amber mode request, level, synchronous to clk.
- light_M1, light_MT, light_M2, light_S  out  3 each  lamp: bit0 green (001), bit1 amber (010), bit2 red (100); registered.
- phase  out  3  current phase: S1=0…S6=5, FLASH=6.
- count  out  CNT_W  tick count within the current phase.
- tick  out  1  prescaler strobe, high for one clk.

## Operation
- Lamp patterns (M1,MT,M2,S): S1 G,R,G,R; S2 G,R,A,R; S3 G,G,R,R; S4 A,A,R,R; S5 R,R,R,G; S6 R,R,R,A; FLASH all 010 when lamp_on, all 000 when lamp off.
- Prescaler: counts 0..PRESCALE−1 and wraps; tick=1 in the clk where it equals PRESCALE−1. With PRESCALE=1, tick is constantly 1.
- Phase/count change only on a tick. On a tick, if count≠T_phase then count+1; else phase end: count←0 and phase advances.
- Advance: S1→S2→S3→S4. From S4: to S5 if side_pend|side_req, else S1. S5→S6→S1.
- side_pend: sticky; set on any clk with side_req=1; cleared on the edge entering S5 (a side_req high in that same clk does not re-set it).
- Flash entry: at any S1–S6 phase end with flash=1, go to FLASH (count←0, lamp_on←1) instead of the normal successor. No mid-phase abort.
- FLASH: on each tick, if flash=0 go to S1, count←0. Else if count=FLASH_T, toggle lamp_on and count←0; else count+1. side_pend is retained through FLASH.
- Illegal phase code (7): next tick forces S1, count 0, S1 lamps.

## Timing
- Reset (async assert, any time, including mid-phase or in FLASH): phase=0, count=0, prescaler=0, side_pend=0, lamp_on=0, tick=0 for PRESCALE>1 and 1 for PRESCALE=1, lamps = S1 pattern (001,100,001,100).
- The first tick arrives PRESCALE clks after reset release.
- Lamps are registered from next-phase decode and change on the same edge as phase; there is no combinational path from inputs to lamps.
- side_req is observed with ≤1 clk latency. A one-clk pulse anywhere in S1–S4 is sufficient to enable S5.
- Counter arithmetic is unsigned CNT_W bits. count never exceeds the current terminal value, so no wrap occurs.
- Cycle length in ticks: 20 without side demand, 27 with it (defaults).

## Test plan
- Defaults, PRESCALE=1, side_req=0: after reset release, phase 0 for 8 clks, 1 for 3, 2 for 6, 3 for 3, then 0 again. Phase 4 never appears. Lamps match the table at every edge.
- One-clk side_req pulse during S2: the sequence continues S4 (3 clks) → S5 (4 clks, light_S=001) → S6 (3 clks, light_S=010) → S1. On the next cycle with no demand, S4→S1.
- flash=1 asserted at S3 count=2: S3 completes to count=5. Then phase=6 with all lamps 010 for 2 ticks, 000 for 2, 010 for 2… Deassert flash: next tick gives phase=0, count=0, S1 lamps.
- PRESCALE=4: tick period is 4 clks, and S1 lasts 32 clks. count increments only on clks where tick=1.
- Async rst pulsed mid-S5 (not aligned to clk): outputs immediately show the reset values and side_pend=0. Without side_req, the following cycle skips S5/S6.
- side_req held high continuously: S5 is taken every cycle, and side_pend is re-set on the clk after entering S5.
